signal_lamp_driver: RTL and testbench

//  Downstream of the traffic controller. Turns its abstract phase outputs (right-lane road select,
//  per-road left-lane greens, pedestrian hold) into safe physical lamp drive: one-hot R/Y/G per head.

---
 rtl/signal_lamp_driver_pkg.sv | 27 ++
 rtl/left_lamp_seq.sv | 67 ++++++
 rtl/signal_lamp_driver.sv | 127 ++++++++++++
 tb/tb_signal_lamp_driver.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/signal_lamp_driver_pkg.sv
// Shared lamp encodings, road codes and FSM state codes for the lamp driver.
// Latency: n/a (types/constants only); backpressure: none.
package signal_lamp_driver_pkg;

    localparam logic [2:0] LAMP_R = 3'b100;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_G = 3'b001;

    localparam logic [1:0] ROAD_A = 2'd0;
    localparam logic [1:0] ROAD_B = 2'd1;
    localparam logic [1:0] ROAD_C = 2'd2;
    localparam logic [1:0] ROAD_D = 2'd3;

    typedef enum logic [1:0] {
        ST_GREEN   = 2'd0,
        ST_YELLOW  = 2'd1,
        ST_ALL_RED = 2'd2,
        ST_WALK    = 2'd3
    } right_state_e;

    typedef enum logic [1:0] {
        LS_RED    = 2'd0,
        LS_GREEN  = 2'd1,
        LS_YELLOW = 2'd2
    } left_state_e;

endpackage

// File: rtl/left_lamp_seq.sv
// One left-turn head: RED -> GREEN -> YELLOW(LEFT_YELLOW) -> RED, lamp is registered-state decode.
// Latency: request seen at a clock edge changes the lamp after that edge; backpressure: none.
module left_lamp_seq
    import signal_lamp_driver_pkg::*;
#(
    parameter int LEFT_YELLOW = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    input  logic       walk_active,
    input  logic       ped_hold,
    output logic [2:0] lamp
);

    localparam logic [7:0] LY_LAST = 8'(LEFT_YELLOW - 1);

    left_state_e state, state_nxt;
    logic [7:0]  timer, timer_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= LS_RED;
            timer <= 8'd0;
        end else begin
            state <= state_nxt;
            timer <= timer_nxt;
        end
    end

    // A request arriving while YELLOW is ignored; the RED state always lasts at least one cycle.
    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        lamp      = LAMP_R;
        case (state)
            LS_RED: begin
                lamp = LAMP_R;
                if (req && !walk_active && !ped_hold) begin
                    state_nxt = LS_GREEN;
                end
            end
            LS_GREEN: begin
                lamp = LAMP_G;
                if (!req || ped_hold) begin
                    state_nxt = LS_YELLOW;
                    timer_nxt = 8'd0;
                end
            end
            LS_YELLOW: begin
                lamp = LAMP_Y;
                if (timer >= LY_LAST) begin
                    state_nxt = LS_RED;
                    timer_nxt = 8'd0;
                end else begin
                    timer_nxt = timer + 8'd1;
                end
            end
            default: begin
                lamp      = LAMP_R;
                state_nxt = LS_RED;
                timer_nxt = 8'd0;
            end
        endcase
    end

endmodule

// File: rtl/signal_lamp_driver.sv
// Turns controller phase requests into one-hot R/Y/G lamp drive with yellow, all-red and walk phases.
// Latency: accepted road change shows new green after YELLOW_TIME+CLEAR_TIME+1 cycles; backpressure: none.
module signal_lamp_driver
    import signal_lamp_driver_pkg::*;
#(
    parameter int YELLOW_TIME = 3,
    parameter int CLEAR_TIME  = 2,
    parameter int MIN_GREEN   = 5,
    parameter int LEFT_YELLOW = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  right_sel,
    input  logic [3:0]  left_req,
    input  logic        ped_hold,
    output logic [11:0] right_lamps,
    output logic [11:0] left_lamps,
    output logic        ped_walk,
    output logic [1:0]  phase
);

    localparam logic [7:0] MG_LAST = 8'(MIN_GREEN - 1);
    localparam logic [7:0] Y_LAST  = 8'(YELLOW_TIME - 1);
    localparam logic [7:0] C_LAST  = 8'(CLEAR_TIME - 1);

    right_state_e state, state_nxt;
    logic [1:0]   cur_road, road_nxt;
    logic [7:0]   cnt, cnt_nxt;
    logic         walk_st;
    logic         left_all_red;

    assign walk_st      = (state == ST_WALK);
    assign left_all_red = (left_lamps == {4{LAMP_R}});
    assign ped_walk     = walk_st && ped_hold;
    assign phase        = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_ALL_RED;
            cur_road <= ROAD_A;
            cnt      <= 8'd0;
        end else begin
            state    <= state_nxt;
            cur_road <= road_nxt;
            cnt      <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        road_nxt  = cur_road;
        cnt_nxt   = cnt;
        case (state)
            ST_GREEN: begin
                // ped_hold skips the minimum-green wait entirely
                if (ped_hold || (cnt >= MG_LAST && right_sel != cur_road)) begin
                    state_nxt = ST_YELLOW;
                    cnt_nxt   = 8'd0;
                end else if (cnt != 8'hFF) begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            ST_YELLOW: begin
                if (cnt >= Y_LAST) begin
                    state_nxt = ST_ALL_RED;
                    cnt_nxt   = 8'd0;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            ST_ALL_RED: begin
                if (cnt >= C_LAST) begin
                    // With ped_hold pending, park here until every left head has cleared to red
                    if (ped_hold) begin
                        if (left_all_red) begin
                            state_nxt = ST_WALK;
                            cnt_nxt   = 8'd0;
                        end
                    end else begin
                        state_nxt = ST_GREEN;
                        road_nxt  = right_sel;
                        cnt_nxt   = 8'd0;
                    end
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            ST_WALK: begin
                if (!ped_hold) begin
                    state_nxt = ST_ALL_RED;
                    cnt_nxt   = 8'd0;
                end
            end
            default: begin
                state_nxt = ST_ALL_RED;
                cnt_nxt   = 8'd0;
            end
        endcase
    end

    always_comb begin
        right_lamps = {4{LAMP_R}};
        for (int i = 0; i < 4; i++) begin
            if (2'(i) == cur_road) begin
                if (state == ST_GREEN) begin
                    right_lamps[3*i +: 3] = LAMP_G;
                end else if (state == ST_YELLOW) begin
                    right_lamps[3*i +: 3] = LAMP_Y;
                end
            end
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_left
        left_lamp_seq #(
            .LEFT_YELLOW (LEFT_YELLOW)
        ) u_left (
            .clk         (clk),
            .reset       (reset),
            .req         (left_req[g]),
            .walk_active (walk_st),
            .ped_hold    (ped_hold),
            .lamp        (left_lamps[3*g +: 3])
        );
    end

endmodule

// File: tb/tb_signal_lamp_driver.sv
// Randomized bench for signal_lamp_driver against a countdown-style behavioural model.
module tb_signal_lamp_driver;
    import signal_lamp_driver_pkg::*;

    localparam int YT = 3;
    localparam int CT = 2;
    localparam int MG = 5;
    localparam int LY = 3;

    localparam int P_GO = 0, P_CAUTION = 1, P_CLEAR = 2, P_PED = 3;

    logic        clk;
    logic        reset;
    logic [1:0]  right_sel;
    logic [3:0]  left_req;
    logic        ped_hold;
    logic [11:0] right_lamps;
    logic [11:0] left_lamps;
    logic        ped_walk;
    logic [1:0]  phase;

    signal_lamp_driver #(
        .YELLOW_TIME (YT),
        .CLEAR_TIME  (CT),
        .MIN_GREEN   (MG),
        .LEFT_YELLOW (LY)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .right_sel   (right_sel),
        .left_req    (left_req),
        .ped_hold    (ped_hold),
        .right_lamps (right_lamps),
        .left_lamps  (left_lamps),
        .ped_walk    (ped_walk),
        .phase       (phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // model: right phase with remaining-time countdown, green age, per-road left colour
    int m_ph, m_rem, m_age, m_road;
    int m_lc[4];   // 0 red, 1 green, 2 yellow
    int m_lrem[4];
    int prev_ph;

    logic [1:0] d_sel;
    logic [3:0] d_req;
    logic       d_ph;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [2:0] colour(input int c);
        if (c == 1) return 3'b001;
        if (c == 2) return 3'b010;
        return 3'b100;
    endfunction

    function automatic logic [11:0] exp_right();
        logic [11:0] v;
        v = 12'h924;
        if (m_ph == P_GO)      v[3*m_road +: 3] = 3'b001;
        if (m_ph == P_CAUTION) v[3*m_road +: 3] = 3'b010;
        return v;
    endfunction

    function automatic logic [11:0] exp_left();
        logic [11:0] v;
        for (int i = 0; i < 4; i++) v[3*i +: 3] = colour(m_lc[i]);
        return v;
    endfunction

    function automatic logic [1:0] exp_phase();
        case (m_ph)
            P_GO:      return ST_GREEN;
            P_CAUTION: return ST_YELLOW;
            P_PED:     return ST_WALK;
            default:   return ST_ALL_RED;
        endcase
    endfunction

    task automatic model_reset();
        m_ph  = P_CLEAR;
        m_rem = CT;
        m_age = 0;
        m_road = 0;
        for (int i = 0; i < 4; i++) begin
            m_lc[i]   = 0;
            m_lrem[i] = 0;
        end
    endtask

    task automatic model_step();
        int  op;
        bit  lred;
        op   = m_ph;
        lred = 1'b1;
        for (int i = 0; i < 4; i++) if (m_lc[i] != 0) lred = 1'b0;
        for (int i = 0; i < 4; i++) begin
            case (m_lc[i])
                0: if (left_req[i] && op != P_PED && !ped_hold) m_lc[i] = 1;
                1: if (!left_req[i] || ped_hold) begin m_lc[i] = 2; m_lrem[i] = LY; end
                default: if (m_lrem[i] <= 1) m_lc[i] = 0; else m_lrem[i]--;
            endcase
        end
        case (op)
            P_GO: begin
                if (ped_hold || (m_age >= MG - 1 && int'(right_sel) != m_road)) begin
                    m_ph = P_CAUTION; m_rem = YT;
                end else if (m_age < 255) m_age++;
            end
            P_CAUTION: begin
                if (m_rem <= 1) begin m_ph = P_CLEAR; m_rem = CT; end
                else m_rem--;
            end
            P_CLEAR: begin
                if (m_rem > 1) m_rem--;
                else if (ped_hold) begin
                    if (lred) m_ph = P_PED;
                end else begin
                    m_road = int'(right_sel); m_ph = P_GO; m_age = 0;
                end
            end
            default: if (!ped_hold) begin m_ph = P_CLEAR; m_rem = CT; end
        endcase
    endtask

    task automatic check_outputs();
        int nonr;
        chk("right_lamps", 32'(right_lamps), 32'(exp_right()));
        chk("left_lamps", 32'(left_lamps), 32'(exp_left()));
        chk("ped_walk", 32'(ped_walk), 32'(m_ph == P_PED && ped_hold));
        chk("phase", 32'(phase), 32'(exp_phase()));
        nonr = 0;
        for (int i = 0; i < 4; i++) begin
            chk("onehot_r", 32'($countones(right_lamps[3*i +: 3])), 32'd1);
            chk("onehot_l", 32'($countones(left_lamps[3*i +: 3])), 32'd1);
            if (right_lamps[3*i +: 3] != 3'b100) nonr++;
        end
        chk("right_excl", 32'(nonr <= 1), 32'd1);
        if (ped_walk) chk("walk_all_red", 32'({right_lamps, left_lamps}), 32'({12'h924, 12'h924}));
    endtask

    task automatic tick(input bit rnd, input bit rel);
        @(negedge clk);
        if (rel) reset = 1'b1;
        if (rnd) begin
            if ($urandom_range(0, 9) == 0) right_sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 39) == 0) ped_hold = ~ped_hold;
            for (int i = 0; i < 4; i++)
                if ($urandom_range(0, 7) == 0) left_req[i] = ~left_req[i];
        end else begin
            right_sel = d_sel;
            left_req  = d_req;
            ped_hold  = d_ph;
        end
        #1;
        check_outputs();
        prev_ph = m_ph;
        if (reset) model_step();
    endtask

    task automatic reset_in_yellow();
        bit found;
        found = 1'b0;
        for (int k = 0; k < 400 && !found; k++) begin
            tick(1'b1, 1'b0);
            if (prev_ph == P_CAUTION) found = 1'b1;
        end
        if (!found) begin
            chk("yellow_seen", 32'd0, 32'd1);
        end else begin
            #1 reset = 1'b0;
            #1;
            chk("async_rst_right", 32'(right_lamps), 32'h924);
            chk("async_rst_left", 32'(left_lamps), 32'h924);
            chk("async_rst_walk", 32'(ped_walk), 32'd0);
            model_reset();
            d_sel = right_sel; d_req = left_req; d_ph = ped_hold;
            tick(1'b0, 1'b0);
            tick(1'b0, 1'b0);
            tick(1'b0, 1'b1);
        end
    endtask

    initial begin
        int lat;
        reset = 1'b0;
        d_sel = 2'b01; d_req = 4'b0000; d_ph = 1'b0;
        right_sel = d_sel; left_req = d_req; ped_hold = d_ph;
        model_reset();

        // reset release with right_sel=B: two all-red cycles, then B green
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        chk("rst_B_green", 32'(right_lamps), 32'h90C);
        chk("rst_left_red", 32'(left_lamps), 32'h924);
        chk("rst_walk_off", 32'(ped_walk), 32'd0);

        // B green at cnt=1 requests C: C must show green 9 cycles later
        d_sel = 2'b10;
        tick(1'b0, 1'b0);
        lat = 0;
        while (lat < 30 && right_lamps != 12'h864) begin
            tick(1'b0, 1'b0);
            lat++;
        end
        chk("lat_B_to_C", 32'(lat), 32'd9);

        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 700; k++) tick(1'b1, 1'b0);
            reset_in_yellow();
        end
        for (int k = 0; k < 50; k++) tick(1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
